// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 encodings, FSM state type and operand-class helpers.
package muldiv_pkg;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      StIdle,
      StCalc,
      StFix,
      StDone
   } state_e;

   function automatic logic is_div(input logic [2:0] f3);
      return f3[2];
   endfunction

   function automatic logic is_signed_a(input logic [2:0] f3);
      return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
             (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

   function automatic logic is_signed_b(input logic [2:0] f3);
      return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One combinational step of the 2*XLEN accumulator: radix-2 shift-add for
// multiply, restoring shift-subtract for divide.
module muldiv_iter #(
   parameter int unsigned XLEN = 32
) (
   input  logic              div_mode,
   input  logic [2*XLEN-1:0] acc,
   input  logic [XLEN-1:0]   opb,
   output logic [2*XLEN-1:0] acc_nxt
);

   logic [XLEN:0]   sum;
   logic [XLEN:0]   rem_ext;
   logic [XLEN+1:0] diff;
   logic            unused_diff;

   // The shifted partial remainder needs XLEN+1 bits before the trial subtract.
   assign rem_ext     = acc[2*XLEN-1:XLEN-1];
   assign diff        = {1'b0, rem_ext} - {2'b00, opb};
   assign sum         = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opb};
   assign unused_diff = diff[XLEN];

   always_comb begin
      acc_nxt = acc;
      if (div_mode) begin
         if (!diff[XLEN+1]) begin
            acc_nxt = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
         end else begin
            acc_nxt = {rem_ext[XLEN-1:0], acc[XLEN-2:0], 1'b0};
         end
      end else if (acc[0]) begin
         acc_nxt = {sum, acc[XLEN-1:1]};
      end else begin
         acc_nxt = {1'b0, acc[2*XLEN-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with start/busy/done handshake.
// Operates on magnitudes and fixes signs in a final cycle.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int unsigned CNT_W = $clog2(XLEN) + 1;
   localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q;
   logic [2*XLEN-1:0] acc_q, acc_nxt;
   logic [XLEN-1:0]   opb_q;
   logic [XLEN-1:0]   result_q;
   logic [2:0]        f3_q;
   logic              neg_res_q, neg_rem_q;

   logic              sa, sb, accept, special, div_zero, div_ovf;
   logic [XLEN-1:0]   mag_a, mag_b, special_res, fix_res;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quo, rem;

   // Operand decode for an incoming request
   always_comb begin
      sa       = is_signed_a(funct3) & a[XLEN-1];
      sb       = is_signed_b(funct3) & b[XLEN-1];
      mag_a    = sa ? -a : a;
      mag_b    = sb ? -b : b;
      div_zero = (b == '0);
      div_ovf  = ((funct3 == F3_DIV) || (funct3 == F3_REM)) && (a == MinNeg) && (b == '1);
      special  = is_div(funct3) & (div_zero | div_ovf);
      if (div_zero) begin
         special_res = funct3[1] ? a : '1;
      end else begin
         special_res = funct3[1] ? '0 : a;
      end
      accept = ((state_q == StIdle) || (state_q == StDone)) && start && !flush;
   end

   muldiv_iter #(
      .XLEN (XLEN)
   ) u_iter (
      .div_mode (is_div(f3_q)),
      .acc      (acc_q),
      .opb      (opb_q),
      .acc_nxt  (acc_nxt)
   );

   // Sign correction of the finished magnitude result
   always_comb begin
      prod = neg_res_q ? -acc_q : acc_q;
      quo  = acc_q[XLEN-1:0];
      rem  = acc_q[2*XLEN-1:XLEN];
      if (is_div(f3_q)) begin
         if (f3_q[1]) begin
            fix_res = neg_rem_q ? -rem : rem;
         end else begin
            fix_res = neg_res_q ? -quo : quo;
         end
      end else begin
         fix_res = (f3_q == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = StIdle;
      end else begin
         case (state_q)
            StIdle, StDone: begin
               if (start) begin
                  state_d = special ? StDone : StCalc;
               end else begin
                  state_d = StIdle;
               end
            end
            StCalc: begin
               if (cnt_q == CNT_W'(1)) begin
                  state_d = StFix;
               end
            end
            StFix:   state_d = StDone;
            default: state_d = StIdle;
         endcase
      end
   end

   always_comb begin
      busy = (state_q == StCalc) || (state_q == StFix);
      done = (state_q == StDone);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q     <= '0;
         acc_q     <= '0;
         opb_q     <= '0;
         f3_q      <= '0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         result_q  <= '0;
      end else if (accept) begin
         cnt_q     <= CNT_W'(XLEN);
         acc_q     <= {{XLEN{1'b0}}, mag_a};
         opb_q     <= mag_b;
         f3_q      <= funct3;
         neg_res_q <= sa ^ sb;
         neg_rem_q <= sa;
         if (special) begin
            result_q <= special_res;
         end
      end else if (!flush) begin
         if (state_q == StCalc) begin
            acc_q <= acc_nxt;
            cnt_q <= cnt_q - 1'b1;
         end
         if (state_q == StFix) begin
            result_q <= fix_res;
         end
      end
   end

   assign result = result_q;

endmodule
